// File: rtl/control_unit.sv
// control_unit: Moore sequencer for the 16-bit processor datapath.
//   clk          processor clock (debounced single-step), rising edge
//   Reset        synchronous active-high reset, wins over every transition
//   IR           current instruction, opcode in IR[15:12]
//   PC_Clr/PC_Up program counter clear / increment
//   IR_Ld        load instruction register
//   D_Addr/D_Wr  data-memory address / write enable
//   RF_*         register-file write select/address/enable, read addresses
//   ALU_s0       ALU function (0 pass A, 1 add, 2 sub)
//   State        current state code, NextState combinational next state
// Outputs decode State and IR only; nothing is registered on the way out.
module control_unit #(
  parameter int DADDR_W = 8,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [15:0]        IR,
  output logic               PC_Clr,
  output logic               PC_Up,
  output logic               IR_Ld,
  output logic [DADDR_W-1:0] D_Addr,
  output logic               D_Wr,
  output logic               RF_s,
  output logic [RADDR_W-1:0] RF_W_addr,
  output logic               RF_W_en,
  output logic [RADDR_W-1:0] RF_Ra_addr,
  output logic [RADDR_W-1:0] RF_Rb_addr,
  output logic [2:0]         ALU_s0,
  output logic [7:0]         State,
  output logic [7:0]         NextState
);

  typedef enum logic [7:0] {
    S_INIT   = 8'h00,
    S_FETCH  = 8'h01,
    S_DECODE = 8'h02,
    S_NOOP   = 8'h03,
    S_LOADA  = 8'h04,
    S_LOADB  = 8'h05,
    S_STORE  = 8'h06,
    S_ADD    = 8'h07,
    S_SUB    = 8'h08,
    S_HALT   = 8'h09
  } state_t;

  state_t state, next_state;

  assign State     = state;
  assign NextState = next_state;

  always_ff @(posedge clk) begin
    if (Reset) state <= S_INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (IR[15:12])
          4'h0:    next_state = S_NOOP;
          4'h1:    next_state = S_STORE;
          4'h2:    next_state = S_LOADA;
          4'h3:    next_state = S_ADD;
          4'h4:    next_state = S_SUB;
          4'h5:    next_state = S_HALT;
          default: next_state = S_NOOP;  // unknown opcodes are skipped
        endcase
      end
      S_LOADA:  next_state = S_LOADB;
      S_NOOP, S_STORE, S_LOADB, S_ADD, S_SUB: next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_INIT;     // unreachable codes recover via Init
    endcase
    // NextState must already show Init while Reset is held
    if (Reset) next_state = S_INIT;
  end

  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = 3'd0;
    case (state)
      S_INIT:  PC_Clr = 1'b1;
      S_FETCH: begin
        IR_Ld = 1'b1;
        PC_Up = 1'b1;
      end
      // LoadA only covers the RAM read latency; LoadB commits the write
      S_LOADA, S_LOADB: begin
        D_Addr    = DADDR_W'(IR[11:4]);
        RF_s      = 1'b1;
        RF_W_addr = RADDR_W'(IR[3:0]);
        RF_W_en   = (state == S_LOADB);
      end
      S_STORE: begin
        D_Addr     = DADDR_W'(IR[11:4]);
        RF_Ra_addr = RADDR_W'(IR[3:0]);
        ALU_s0     = 3'd0;
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = RADDR_W'(IR[11:8]);
        RF_Rb_addr = RADDR_W'(IR[7:4]);
        RF_W_addr  = RADDR_W'(IR[3:0]);
        RF_s       = 1'b0;
        RF_W_en    = 1'b1;
        ALU_s0     = (state == S_SUB) ? 3'd2 : 3'd1;
      end
      default: ;  // Decode, NoOp, Halt drive nothing
    endcase
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM that sequences the 16-bit processor datapath: PC, instruction register, data memory, register file and ALU.
- Sits inside the processor beside the datapath. It is clocked by the debounced single-step clock and reset by the board reset.
- Exports its current and next state codes so the top level can show them on the HEX displays.

Parameters:
- DADDR_W, 8, data-memory address width (taken from IR[11:4])
- RADDR_W, 4, register-file address width

Ports:
- clk  input  1  processor clock; all state changes on the rising edge
- Reset  input  1  synchronous, active-high reset
- IR  input  16  current instruction; opcode is IR[15:12]
- PC_Clr  output  1  clear program counter
- PC_Up  output  1  increment program counter
- IR_Ld  output  1  load instruction register from instruction memory
- D_Addr  output  DADDR_W  data-memory address
- D_Wr  output  1  data-memory write enable
- RF_s  output  1  register-file write-data select: 1 = memory, 0 = ALU
- RF_W_addr  output  RADDR_W  register-file write address
- RF_W_en  output  1  register-file write enable
- RF_Ra_addr  output  RADDR_W  read port A address
- RF_Rb_addr  output  RADDR_W  read port B address
- ALU_s0  output  3  ALU function: 0 = pass A, 1 = A+B, 2 = A-B
- State  output  8  current state code
- NextState  output  8  combinational next-state code

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. Reset has priority over every transition and forces State to Init on the next clk edge, from any state, including mid-Load and Halt.
- State codes (8-bit):
  - Init 8'h00, Fetch 8'h01, Decode 8'h02, NoOp 8'h03
  - LoadA 8'h04, LoadB 8'h05, Store 8'h06, Add 8'h07, Sub 8'h08, Halt 8'h09
- Transitions:
  - Init -> Fetch -> Decode.
  - Decode dispatches on IR[15:12]: 0000 NoOp, 0001 Store, 0010 LoadA, 0011 Add, 0100 Sub, 0101 Halt. Any other opcode -> NoOp.
  - NoOp, Store, LoadB, Add and Sub each -> Fetch.
  - LoadA -> LoadB.
  - Halt -> Halt until Reset.
- NextState is the combinational next-state value, and equals Init whenever Reset=1.
- Outputs are a pure function of State and IR. There are no output registers.
- Default value of every output in every state is 0. States assert only the following:
  - Init: PC_Clr=1.
  - Fetch: IR_Ld=1, PC_Up=1. IR holds the new instruction from the following cycle (Decode).
  - Decode, NoOp, Halt: all outputs 0.
  - LoadA: D_Addr=IR[11:4], RF_s=1, RF_W_addr=IR[3:0], RF_W_en=0. This cycle covers the synchronous RAM read latency.
  - LoadB: same as LoadA plus RF_W_en=1. Register IR[3:0] is written from memory at the end of LoadB.
  - Store: D_Addr=IR[11:4], RF_Ra_addr=IR[3:0], ALU_s0=0, D_Wr=1 for exactly one cycle.
  - Add: RF_Ra_addr=IR[11:8], RF_Rb_addr=IR[7:4], RF_W_addr=IR[3:0], RF_s=0, ALU_s0=1, RF_W_en=1.
  - Sub: same as Add with ALU_s0=2.
- Reset value: after a reset edge, State=8'h00, PC_Clr=1, and every other output is 0.
- Instruction latency: NoOp, Store, Add and Sub take 3 cycles (Fetch, Decode, Execute). Load takes 4.
- Write pulses: D_Wr and RF_W_en are never asserted in two consecutive cycles by the same instruction. They are never asserted in Init, Fetch, Decode or Halt.
- PC_Up is asserted only in Fetch. PC wrap-around is the PC's responsibility.
- Reset asserted during Store or LoadB: the write pulse in that cycle still occurs, because outputs follow current State. The next cycle is Init.

Test Plan:
- Reset: hold Reset 2 cycles from an unknown state -> State=8'h00, PC_Clr=1, all other outputs 0. Release -> State sequence 01, 02.
- Add: IR=16'h3123 at Decode -> State 8'h07 with RF_Ra_addr=1, RF_Rb_addr=2, RF_W_addr=3, ALU_s0=1, RF_W_en=1, RF_s=0. Then State 8'h01.
- Load: IR=16'h2AB5 -> LoadA with D_Addr=8'hAB, RF_s=1, RF_W_en=0. Then LoadB with RF_W_en=1, RF_W_addr=5. Then Fetch (4 cycles total).
- Store/Sub: IR=16'h1CD7 -> Store with D_Addr=8'hCD, RF_Ra_addr=7, D_Wr high exactly 1 cycle. IR=16'h4456 -> Sub with ALU_s0=2.
- Halt and illegal opcode: IR=16'h5000 -> State stays 8'h09 for 20 cycles with no PC_Up; Reset -> Init. IR=16'hF123 -> NoOp (8'h03) then Fetch.
- Mid-operation reset: assert Reset during LoadA -> next State=8'h00, with no RF_W_en pulse on that edge or after it. NextState reads 8'h00 while Reset=1.
